vga: RTL and testbench
======================

Name: vga

Overview:
- VGA 640x480@60 Hz timing generator and pixel output stage. Clocked by the 25 MHz pixel clock `pll`.
- Publishes the current scan coordinates `x_pos`/`y_pos` to the game renderer.
- The renderer answers combinationally with `color`. The block registers it onto `rgb` together with the sync pulses.
- Sits between the game logic and the board's 3-bit VGA connector.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- pll  input  1  pixel clock, 25 MHz; the only clock in the block
- rst_n  input  1  asynchronous active-low reset
- game_clk  input  1  game-logic clock, asynchronous to `pll`; used as data only, never as a clock
- color  input  3  renderer pixel colour {R,G,B} for the current `x_pos`/`y_pos`
- rgb  output  3  VGA colour {R,G,B}
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- x_pos  output  10  current horizontal count, 0..799
- y_pos  output  10  current vertical count, 0..524

Behaviour:
- H_TOTAL = sum of the H parameters = 800; V_TOTAL = sum of the V parameters = 525.
- Horizontal counter:
  - Registered; increments every `pll` rising edge.
  - Wraps H_TOTAL-1 -> 0.
- Vertical counter:
  - Increments only on the cycle where h wraps.
  - Wraps V_TOTAL-1 -> 0 when both counters are at their maximum.
  - Frame = 420000 clocks.
- `x_pos` = h counter and `y_pos` = v counter, both driven directly from the registers (zero latency).
- Visible region: `x_pos` < H_VISIBLE and `y_pos` < V_VISIBLE.
- Sync decode from the current counters:
  - hs_raw low when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs_raw low when 490 <= v < 492.
- Output stage, one register stage, latency 1 clock:
  - `hsync` <= hs_raw, `vsync` <= vs_raw.
  - `rgb` <= visible ? `color` : 3'b000.
  - Sync and colour therefore stay mutually aligned; both lag the coordinates by one cycle.
- `color` is sampled only at the `pll` edge. It is ignored, and `rgb` = 0, outside the visible region including all porches and sync periods.
- `game_clk` handling:
  - Passes through a 2-flop synchronizer in the `pll` domain, reset to 0.
  - The synchronized value has no effect on any output in the base build.
  - `game_clk` must never be used as a clock edge.
- Reset (async assert, sync release on `pll`):
  - h = 0, v = 0, so `x_pos` = 0 and `y_pos` = 0.
  - `hsync` = 1, `vsync` = 1, `rgb` = 0.
  - Synchronizer flops = 0.
- Reset mid-frame: outputs return to the reset values immediately. Counting restarts at (0,0) on the first `pll` edge after `rst_n` rises.
- No illegal counter states are reachable. If h or v ever holds a value >= its total, the next edge loads 0.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: `color` is ignored. In the visible region `rgb` is registered as the 3-bit bar index `x_pos`/80, giving 8 vertical colour bars (0..7 left to right). Blanking and sync behaviour are unchanged.
- Undefined: normal behaviour, `rgb` taken from `color`.

Test Plan:
- Reset: hold `rst_n`=0 over several `pll` edges -> `x_pos`=0, `y_pos`=0, `hsync`=1, `vsync`=1, `rgb`=0; release -> `x_pos` counts 1,2,3... on successive edges.
- Line timing: run one line with `color`=3'b101 ->
  - `rgb`=101 on the 640 clocks following `x_pos`=0..639, then 000.
  - `hsync` low for exactly 96 clocks, first low cycle one clock after `x_pos`=656.
  - Line period 800 clocks.
- Frame timing: run 420000 clocks ->
  - `y_pos` advances 0..524 and wraps to 0 with `x_pos`=0.
  - `vsync` low for exactly 1600 clocks, starting one clock after (`x_pos`=0, `y_pos`=490).
- Blanking: `color`=3'b111 constant -> `rgb`=0 for every cycle where the previous coordinate had `y_pos` >= 480 or `x_pos` >= 640.
- Mid-frame reset: assert `rst_n`=0 at `x_pos`=300, `y_pos`=200 -> immediate `rgb`=0, `hsync`=`vsync`=1; after release, counting restarts at (0,0).
- With VGA_TEST_PATTERN_EN: `color`=0 -> `rgb` = 0 for pixels 0..79, 1 for 80..159, ..., 7 for 560..639, 0 in blanking.

Source files
------------

// File: rtl/vga.sv
// VGA 640x480@60 timing generator with a registered pixel/sync output stage.
// Define VGA_TEST_PATTERN_EN to replace the renderer colour with 8 colour bars.
module vga #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       pll,
  input  logic       rst_n,
  input  logic       game_clk,
  input  logic [2:0] color,
  output logic [2:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q;
  logic       vsync_q;
  logic [2:0] rgb_q, rgb_d;
  logic [1:0] gsync_q;
  logic       visible;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] pix;
  logic       unused_sig;

  // Out-of-range counts fall back to 0 so the scan always recovers.
  always_comb begin
    h_d = (h_q >= H_MAX) ? '0 : h_q + 10'd1;
    v_d = (v_q > V_MAX) ? '0 : v_q;
    if (h_q >= H_MAX) begin
      v_d = (v_q >= V_MAX) ? '0 : v_q + 10'd1;
    end
  end

  assign visible = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_raw  = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_raw  = !((v_q >= VS_BEG) && (v_q < VS_END));

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] bar;
  assign bar        = h_q / 10'd80;
  assign pix        = bar[2:0];
  assign unused_sig = ^{gsync_q[1], bar[9:3], color};
`else
  assign pix        = color;
  assign unused_sig = gsync_q[1];
`endif

  assign rgb_d = visible ? pix : 3'b000;

  always_ff @(posedge pll or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
      gsync_q <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hs_raw;
      vsync_q <= vs_raw;
      rgb_q   <= rgb_d;
      gsync_q <= {gsync_q[0], game_clk};
    end
  end

  assign x_pos = h_q;
  assign y_pos = v_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga.sv
// Directed bench for the vga timing generator.
// Long vertical stretches are skipped by loading the scan counters.
module tb_vga;

  logic       pll = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_clk = 1'b0;
  logic [2:0] color = 3'b000;
  logic [2:0] rgb;
  logic       hsync;
  logic       vsync;
  logic [9:0] x_pos;
  logic [9:0] y_pos;

  int errors = 0;
  int checks = 0;
  int ex = 0;
  int ey = 0;
  int bad, hs_low, vs_low, rgb_on;
  int hs_fx, vs_fx, vs_fy;
  logic [9:0] jh, jv;

`ifdef VGA_TEST_PATTERN_EN
  localparam int RGB_LINE = 560;
`else
  localparam int RGB_LINE = 640;
`endif

  always #20 pll = ~pll;
  always #17 game_clk = ~game_clk;

  vga dut (
    .pll      (pll),
    .rst_n    (rst_n),
    .game_clk (game_clk),
    .color    (color),
    .rgb      (rgb),
    .hsync    (hsync),
    .vsync    (vsync),
    .x_pos    (x_pos),
    .y_pos    (y_pos)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_rgb(input int px, input int py,
                                         input logic [2:0] c);
    if (px >= 640 || py >= 480) return 3'b000;
`ifdef VGA_TEST_PATTERN_EN
    return 3'(px / 80);
`else
    return c;
`endif
  endfunction

  task automatic step();
    @(posedge pll);
    #1;
  endtask

  task automatic clr();
    bad = 0; hs_low = 0; vs_low = 0; rgb_on = 0;
    hs_fx = -1; vs_fx = -1; vs_fy = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      int px;
      int py;
      px = ex;
      py = ey;
      step();
      ex++;
      if (ex == 800) begin
        ex = 0;
        ey = (ey == 524) ? 0 : ey + 1;
      end
      if (x_pos !== 10'(ex) || y_pos !== 10'(ey)) bad++;
      if (rgb !== exp_rgb(px, py, color)) bad++;
      if (hsync !== !(px >= 656 && px < 752)) bad++;
      if (vsync !== !(py >= 490 && py < 492)) bad++;
      if (hsync === 1'b0) begin
        hs_low++;
        if (hs_fx < 0) hs_fx = px;
      end
      if (vsync === 1'b0) begin
        vs_low++;
        if (vs_fx < 0) begin
          vs_fx = px;
          vs_fy = py;
        end
      end
      if (rgb !== 3'b000) rgb_on++;
    end
  endtask

  task jump(input int h, input int v);
    @(negedge pll);
    jh = 10'(h);
    jv = 10'(v);
    force dut.h_q = jh;
    force dut.v_q = jv;
    #1;
    release dut.h_q;
    release dut.v_q;
    ex = h;
    ey = v;
  endtask

  initial begin
    rst_n = 1'b0;
    color = 3'b000;
    repeat (4) @(posedge pll);
    #1;
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb", rgb, 0);

    @(negedge pll);
    rst_n = 1'b1;
    step();
    chk("count1", x_pos, 1);
    step();
    chk("count2", x_pos, 2);
    step();
    chk("count3", x_pos, 3);
    chk("count_y", y_pos, 0);
    ex = 3;
    ey = 0;

    color = 3'b101;
    clr();
    run(797);
    chk("line0_model", bad, 0);
    clr();
    run(800);
    chk("line1_model", bad, 0);
    chk("hsync_width", hs_low, 96);
    chk("hsync_first", hs_fx, 656);
    chk("rgb_active_cnt", rgb_on, RGB_LINE);
    chk("line_period_x", x_pos, 0);
    chk("line_period_y", y_pos, 2);

    color = 3'b111;
    jump(0, 479);
    clr();
    run(2400);
    chk("blank_model", bad, 0);
    chk("blank_rgb_cnt", rgb_on, RGB_LINE);
    chk("blank_no_vsync", vs_low, 0);

    jump(0, 489);
    clr();
    run(3200);
    chk("vsync_model", bad, 0);
    chk("vsync_width", vs_low, 1600);
    chk("vsync_first_x", vs_fx, 0);
    chk("vsync_first_y", vs_fy, 490);

    jump(790, 524);
    clr();
    run(10);
    chk("wrap_model", bad, 0);
    chk("wrap_x", x_pos, 0);
    chk("wrap_y", y_pos, 0);

    jump(295, 200);
    clr();
    run(5);
    chk("pre_rst_model", bad, 0);
    chk("pre_rst_x", x_pos, 300);
    chk("pre_rst_rgb", rgb, exp_rgb(299, 200, color));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_hsync", hsync, 1);
    chk("mid_rst_vsync", vsync, 1);
    chk("mid_rst_x", x_pos, 0);
    chk("mid_rst_y", y_pos, 0);
    repeat (3) @(posedge pll);
    #1;
    chk("hold_rst_x", x_pos, 0);
    @(negedge pll);
    rst_n = 1'b1;
    step();
    chk("restart_x", x_pos, 1);
    chk("restart_y", y_pos, 0);

    jump(1000, 600);
    step();
    chk("illegal_x", x_pos, 0);
    chk("illegal_y", y_pos, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
